// File: rtl/dmem_block_mover.sv
// Data-memory block mover: copies src->dst or fills dst with a constant, one memory
// access per busy cycle, with all memory-port outputs registered.
module dmem_block_mover #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] fill_q;
  logic              mode_q;

  // Outputs are registered alongside the state: each branch sets them to the values
  // the next state must present, so nothing combinational reaches the memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      fill_q    <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          mem_wr_en <= 1'b0;
          if (start) begin
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            cnt_q    <= len;
            fill_q   <= fill_val;
            mode_q   <= mode_fill;
            mem_addr <= dst_addr;
            if (len == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              mem_wdata <= buf_q;
            end else if (mode_fill) begin
              state     <= WR;
              buf_q     <= fill_val;
              busy      <= 1'b1;
              mem_wr_en <= 1'b1;
              mem_wdata <= fill_val;
            end else begin
              state     <= RD;
              busy      <= 1'b1;
              mem_addr  <= src_addr;
              mem_wdata <= buf_q;
            end
          end else begin
            busy      <= 1'b0;
            mem_addr  <= dst_q;
            mem_wdata <= buf_q;
          end
        end

        RD: begin
          state     <= WR;
          buf_q     <= mem_rdata;
          src_q     <= src_q + ADDR_W'(1);
          busy      <= 1'b1;
          mem_addr  <= dst_q;
          mem_wdata <= mem_rdata;
          mem_wr_en <= 1'b1;
        end

        WR: begin
          dst_q     <= dst_q + ADDR_W'(1);
          cnt_q     <= cnt_q - LEN_W'(1);
          mem_wr_en <= 1'b0;
          if (cnt_q == LEN_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            mem_addr  <= dst_q + ADDR_W'(1);
            mem_wdata <= buf_q;
          end else if (mode_q) begin
            state     <= WR;
            buf_q     <= fill_q;
            mem_addr  <= dst_q + ADDR_W'(1);
            mem_wdata <= fill_q;
            mem_wr_en <= 1'b1;
          end else begin
            state     <= RD;
            mem_addr  <= src_q;
            mem_wdata <= buf_q;
          end
        end

        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          mem_wr_en <= 1'b0;
          mem_addr  <= dst_q;
          mem_wdata <= buf_q;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Directed bench for dmem_block_mover: behavioural 64K-word memory, per-command
// latency/pulse counting, and memory-content checks against hand-computed values.
module tb_dmem_block_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode_fill;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic [15:0] fill_val;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  int          wr_cnt = 0;
  logic [15:0] wr_log [$];

  always #5 clk = ~clk;

  dmem_block_mover #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_fill(mode_fill),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_log.push_back(mem_addr);
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic logic [15:0] init_val(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command and watches it to completion; optionally pulses a second
  // start (fill dst=0x60 len=2 val=0xFFFF) in cycle inj_cyc while the first is running.
  task automatic run_cmd(input logic mf, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [15:0] fv, input int inj_cyc,
                         output int busy_cnt, output int done_cyc, output int done_cnt,
                         output int writes);
    int w0;
    int budget;
    @(negedge clk);
    w0 = wr_cnt;
    mode_fill = mf; src_addr = s; dst_addr = d; len = l; fill_val = fv; start = 1'b1;
    busy_cnt = 0; done_cyc = 0; done_cnt = 0;
    budget = 2 * int'(l) + 6;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        mode_fill = ~mf; src_addr = 16'h0300; dst_addr = 16'h0310; len = 16'd9; fill_val = 16'hDEAD;
      end
      if (cyc == inj_cyc) begin
        mode_fill = 1'b1; dst_addr = 16'h0060; len = 16'd2; fill_val = 16'hFFFF; start = 1'b1;
      end
      if (cyc == inj_cyc + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc > done_cyc + 1) break;
    end
    writes = wr_cnt - w0;
  endtask

  int bc, dc, dn, wc, q0, w0, done_seen;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
    mem[16'h10] = 16'h00A1; mem[16'h11] = 16'h00B2;
    mem[16'h12] = 16'h00C3; mem[16'h13] = 16'h00D4;
    start = 1'b0; mode_fill = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;

    // Copy of four words
    run_cmd(1'b0, 16'h0010, 16'h0020, 16'd4, 16'h0000, 0, bc, dc, dn, wc);
    check("copy_busy", 32'(bc), 8);
    check("copy_done_cyc", 32'(dc), 9);
    check("copy_done_cnt", 32'(dn), 1);
    check("copy_writes", 32'(wc), 4);
    check("copy_m20", 32'(mem[16'h20]), 32'h00A1);
    check("copy_m21", 32'(mem[16'h21]), 32'h00B2);
    check("copy_m22", 32'(mem[16'h22]), 32'h00C3);
    check("copy_m23", 32'(mem[16'h23]), 32'h00D4);
    check("copy_m24", 32'(mem[16'h24]), 32'(init_val(16'h24)));

    // Fill of three words
    run_cmd(1'b1, 16'h0000, 16'h0005, 16'd3, 16'hBEEF, 0, bc, dc, dn, wc);
    check("fill_busy", 32'(bc), 3);
    check("fill_done_cyc", 32'(dc), 4);
    check("fill_writes", 32'(wc), 3);
    check("fill_m4", 32'(mem[4]), 32'(init_val(4)));
    check("fill_m5", 32'(mem[5]), 32'hBEEF);
    check("fill_m6", 32'(mem[6]), 32'hBEEF);
    check("fill_m7", 32'(mem[7]), 32'hBEEF);
    check("fill_m8", 32'(mem[8]), 32'(init_val(8)));

    // Zero-length commands in both modes
    run_cmd(1'b0, 16'h0010, 16'h0030, 16'd0, 16'h0000, 0, bc, dc, dn, wc);
    check("len0c_busy", 32'(bc), 0);
    check("len0c_done_cyc", 32'(dc), 1);
    check("len0c_writes", 32'(wc), 0);
    run_cmd(1'b1, 16'h0000, 16'h0030, 16'd0, 16'h7777, 0, bc, dc, dn, wc);
    check("len0f_busy", 32'(bc), 0);
    check("len0f_done_cyc", 32'(dc), 1);
    check("len0f_writes", 32'(wc), 0);
    check("len0_m30", 32'(mem[16'h30]), 32'(init_val(16'h30)));

    // Address wrap
    q0 = wr_log.size();
    run_cmd(1'b1, 16'h0000, 16'hFFFE, 16'd3, 16'h0001, 0, bc, dc, dn, wc);
    check("wrap_writes", 32'(wc), 3);
    if (wr_log.size() >= q0 + 3) begin
      check("wrap_addr0", 32'(wr_log[q0]), 32'hFFFE);
      check("wrap_addr1", 32'(wr_log[q0+1]), 32'hFFFF);
      check("wrap_addr2", 32'(wr_log[q0+2]), 32'h0000);
    end
    check("wrap_mFFFF", 32'(mem[16'hFFFF]), 1);
    check("wrap_m0000", 32'(mem[0]), 1);
    check("wrap_m0001", 32'(mem[1]), 32'(init_val(1)));

    // Second start mid-copy is ignored; next start after done is accepted
    run_cmd(1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0000, 3, bc, dc, dn, wc);
    check("ign_busy", 32'(bc), 8);
    check("ign_done_cyc", 32'(dc), 9);
    check("ign_writes", 32'(wc), 4);
    check("ign_m43", 32'(mem[16'h43]), 32'h00D4);
    check("ign_m60", 32'(mem[16'h60]), 32'(init_val(16'h60)));
    run_cmd(1'b1, 16'h0000, 16'h0060, 16'd2, 16'h1234, 0, bc, dc, dn, wc);
    check("after_done_cyc", 32'(dc), 3);
    check("after_m61", 32'(mem[16'h61]), 32'h1234);

    // Asynchronous reset during the write of word 2 of a 4-word copy
    @(negedge clk);
    w0 = wr_cnt;
    mode_fill = 1'b0; src_addr = 16'h0010; dst_addr = 16'h0080; len = 16'd4; start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    check("ar_pre_wr_en", 32'(mem_wr_en), 1);
    check("ar_pre_addr", 32'(mem_addr), 32'h0081);
    #1 rst = 1'b1;
    #1;
    check("ar_wr_en_drop", 32'(mem_wr_en), 0);
    check("ar_busy_drop", 32'(busy), 0);
    done_seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (cyc == 3) rst = 1'b0;
      if (done) done_seen++;
    end
    check("ar_no_done", 32'(done_seen), 0);
    check("ar_writes", 32'(wr_cnt - w0), 1);
    check("ar_m80", 32'(mem[16'h80]), 32'h00A1);
    check("ar_m82", 32'(mem[16'h82]), 32'(init_val(16'h82)));
    check("ar_m83", 32'(mem[16'h83]), 32'(init_val(16'h83)));
    run_cmd(1'b1, 16'h0000, 16'h0082, 16'd2, 16'hCAFE, 0, bc, dc, dn, wc);
    check("ar_new_done_cyc", 32'(dc), 3);
    check("ar_new_m83", 32'(mem[16'h83]), 32'hCAFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
